// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC, picks the next PC by redirect
// priority and drives a timed flush of wrong-path IF/ID contents.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   stall_i                hazard freeze of IF/ID
//   invalid_overflow_i     exception request, exc_pc_i faulting PC
//   branch_i/branch_target_i, jump_i/jump_target_i, eret_i
//   pc_o, flush_o, epc_o, exc_pending_o, last_src_o (all registered)
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        invalid_overflow_i,
  input  logic [31:0] exc_pc_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        eret_i,
  output logic [31:0] pc_o,
  output logic        flush_o,
  output logic [31:0] epc_o,
  output logic        exc_pending_o,
  output logic [1:0]  last_src_o
);

  typedef enum logic {RUN, FLUSH} state_e;

  localparam logic [3:0] FcntInit = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic [31:0] epc_q, epc_d;
  logic        pend_q, pend_d;
  logic [1:0]  src_q, src_d;

  logic        eret_ok;
  logic        redir;
  logic [31:0] pc_seq;

  // eret without an active handler is not a redirect
  assign eret_ok = eret_i & pend_q;
  assign redir   = invalid_overflow_i | branch_i
                 | jump_i | eret_ok;
  assign pc_seq  = pc_q + 32'd2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      fcnt_q  <= 4'd0;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      epc_q   <= 32'd0;
      pend_q  <= 1'b0;
      src_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= {pc_d[31:1], 1'b0};
      flush_q <= flush_d;
      epc_q   <= epc_d;
      pend_q  <= pend_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (redir) state_d = FLUSH;
      end
      FLUSH: begin
        if (!stall_i && fcnt_q == 4'd1)
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    fcnt_d  = fcnt_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    epc_d   = epc_q;
    pend_d  = pend_q;
    src_d   = src_q;
    unique case (state_q)
      RUN: begin
        if (invalid_overflow_i) begin
          pc_d  = EXC_VECTOR;
          src_d = 2'b11;
          // nested exception keeps the first context
          if (!pend_q) begin
            epc_d  = exc_pc_i;
            pend_d = 1'b1;
          end
        end else if (branch_i) begin
          pc_d  = branch_target_i;
          src_d = 2'b10;
        end else if (jump_i) begin
          pc_d  = jump_target_i;
          src_d = 2'b01;
        end else if (eret_ok) begin
          pc_d   = epc_q;
          pend_d = 1'b0;
          src_d  = 2'b01;
        end else if (!stall_i) begin
          pc_d  = pc_seq;
          src_d = 2'b00;
        end
        if (redir) begin
          fcnt_d  = FcntInit;
          flush_d = 1'b1;
        end
      end
      FLUSH: begin
        if (!stall_i) begin
          pc_d   = pc_seq;
          src_d  = 2'b00;
          fcnt_d = fcnt_q - 4'd1;
          if (fcnt_q == 4'd1) flush_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign pc_o          = pc_q;
  assign flush_o       = flush_q;
  assign epc_o         = epc_q;
  assign exc_pending_o = pend_q;
  assign last_src_o    = src_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus, reference model
// feeds a scoreboard queue drained by an independent monitor.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_V  = 32'h0000_0080;
  localparam int          FC     = 2;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        ov;
  logic [31:0] exc_pc;
  logic        br;
  logic [31:0] bt;
  logic        jp;
  logic [31:0] jt;
  logic        er;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] epc;
  logic        pend;
  logic [1:0]  src;

  pc_sequencer #(
    .RESET_PC(RST_PC),
    .EXC_VECTOR(EXC_V),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .stall_i(stall),
    .invalid_overflow_i(ov),
    .exc_pc_i(exc_pc),
    .branch_i(br),
    .branch_target_i(bt),
    .jump_i(jp),
    .jump_target_i(jt),
    .eret_i(er),
    .pc_o(pc),
    .flush_o(flush),
    .epc_o(epc),
    .exc_pending_o(pend),
    .last_src_o(src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        fl;
    logic [31:0] epc;
    logic        pend;
    logic [1:0]  src;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  // reference state: remaining flush cycles instead of an FSM
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_pend;
  logic [1:0]  m_src;
  int          m_left;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = RST_PC;
    m_epc  = 32'd0;
    m_pend = 1'b0;
    m_src  = 2'b00;
    m_left = 0;
  endtask

  task automatic model_step();
    exp_t e;
    if (m_left == 0) begin
      if (ov) begin
        m_pc  = EXC_V;
        m_src = 2'b11;
        if (!m_pend) begin
          m_epc  = exc_pc;
          m_pend = 1'b1;
        end
        m_left = FC;
      end else if (br) begin
        m_pc   = bt & ~32'd1;
        m_src  = 2'b10;
        m_left = FC;
      end else if (jp) begin
        m_pc   = jt & ~32'd1;
        m_src  = 2'b01;
        m_left = FC;
      end else if (er && m_pend) begin
        m_pc   = m_epc & ~32'd1;
        m_pend = 1'b0;
        m_src  = 2'b01;
        m_left = FC;
      end else if (!stall) begin
        m_pc  = m_pc + 32'd2;
        m_src = 2'b00;
      end
    end else if (!stall) begin
      m_pc  = m_pc + 32'd2;
      m_src = 2'b00;
      m_left--;
    end
    e.pc   = m_pc;
    e.fl   = (m_left != 0);
    e.epc  = m_epc;
    e.pend = m_pend;
    e.src  = m_src;
    sb.push_back(e);
  endtask

  task automatic drive(input logic a_ov,
                       input logic [31:0] a_ep,
                       input logic a_br,
                       input logic [31:0] a_bt,
                       input logic a_jp,
                       input logic [31:0] a_jt,
                       input logic a_er,
                       input logic a_st);
    ov     = a_ov;
    exc_pc = a_ep;
    br     = a_br;
    bt     = a_bt;
    jp     = a_jp;
    jt     = a_jt;
    er     = a_er;
    stall  = a_st;
    model_step();
  endtask

  task automatic step(input logic a_ov,
                      input logic [31:0] a_ep,
                      input logic a_br,
                      input logic [31:0] a_bt,
                      input logic a_jp,
                      input logic [31:0] a_jt,
                      input logic a_er,
                      input logic a_st);
    @(negedge clk);
    drive(a_ov, a_ep, a_br, a_bt, a_jp, a_jt, a_er, a_st);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("sb_pc", pc, me.pc);
      chk("sb_flush", 32'(flush), 32'(me.fl));
      chk("sb_epc", epc, me.epc);
      chk("sb_pend", 32'(pend), 32'(me.pend));
      chk("sb_src", 32'(src), 32'(me.src));
    end
  end

  initial begin
    rst_n = 1'b0;
    stall = 0; ov = 0; exc_pc = 0;
    br = 0; bt = 0; jp = 0; jt = 0; er = 0;
    model_reset();
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_epc", epc, 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_src", 32'(src), 0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    settle();
    chk("seq_pc6", pc, 32'h6);
    chk("seq_flush", 32'(flush), 0);
    idle(5);
    settle();
    chk("seq_pc10", pc, 32'h10);

    step(0, 0, 1, 32'h40, 1, 32'h80, 0, 0);
    settle();
    chk("prio_pc", pc, 32'h40);
    chk("prio_src", 32'(src), 2);
    chk("prio_flush", 32'(flush), 1);
    step(0, 0, 0, 0, 1, 32'h200, 0, 0);
    settle();
    chk("fl_ign_pc", pc, 32'h42);
    chk("fl_ign_flush", 32'(flush), 1);
    idle(1);
    settle();
    chk("fl_end_pc", pc, 32'h44);
    chk("fl_end_flush", 32'(flush), 0);

    step(1, 32'h1C, 0, 0, 0, 0, 0, 0);
    settle();
    chk("exc_pc", pc, 32'h80);
    chk("exc_epc", epc, 32'h1C);
    chk("exc_pend", 32'(pend), 1);
    chk("exc_src", 32'(src), 3);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("eret_pc", pc, 32'h1C);
    chk("eret_pend", 32'(pend), 0);
    chk("eret_src", 32'(src), 1);
    idle(2);

    step(1, 32'h1C, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 32'h90, 0, 0, 0, 0, 0, 0);
    settle();
    chk("nest_pc", pc, 32'h80);
    chk("nest_epc", epc, 32'h1C);
    chk("nest_pend", 32'(pend), 1);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    settle();
    chk("ret2_pc", pc, 32'h20);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("spur_pc", pc, 32'h22);
    chk("spur_flush", 32'(flush), 0);

    step(0, 0, 1, 32'h100, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    chk("stl_pc", pc, 32'h100);
    chk("stl_flush", 32'(flush), 1);
    idle(1);
    settle();
    chk("stl_pc2", pc, 32'h102);
    chk("stl_flush2", 32'(flush), 1);
    idle(1);
    settle();
    chk("stl_flush3", 32'(flush), 0);

    step(0, 0, 1, 32'h41, 0, 0, 0, 1);
    settle();
    chk("odd_pc", pc, 32'h40);
    chk("odd_src", 32'(src), 2);
    idle(2);

    step(1, 32'h50, 0, 0, 0, 0, 0, 0);
    settle();
    chk("mid_flush", 32'(flush), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, RST_PC);
    chk("arst_flush", 32'(flush), 0);
    chk("arst_pend", 32'(pend), 0);
    chk("arst_epc", epc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    step(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 99) < 5,
            $urandom,
            $urandom_range(0, 99) < 10,
            $urandom,
            $urandom_range(0, 99) < 10,
            $urandom,
            $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 25);
    end
    settle();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
